// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: func3 op codes,
// FSM state type and operand-signedness helpers.
package rv_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic src1_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic src2_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle between the core (master) and the multiply/divide unit (slave).
interface rv_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/rv_mdu_signfix.sv
// Combinational sign conditioning: negates two XLEN halves independently or
// as one 2*XLEN value, then optionally swaps so the selected half sits low.
module rv_mdu_signfix
  import rv_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   in_lo,
  input  logic [XLEN-1:0]   in_hi,
  input  logic              neg_lo,
  input  logic              neg_hi,
  input  logic              wide,
  input  logic              sel_hi,
  output logic [2*XLEN-1:0] res
);

  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   hi;

  // In wide mode neg_lo governs the whole 2*XLEN value; neg_hi is ignored.
  always_comb begin
    full = {in_hi, in_lo};
    if (neg_lo) full = '0 - full;
    lo = neg_lo ? ('0 - in_lo) : in_lo;
    hi = neg_hi ? ('0 - in_hi) : in_hi;
    if (wide) begin
      lo = full[XLEN-1:0];
      hi = full[2*XLEN-1:XLEN];
    end
    res = sel_hi ? {lo, hi} : {hi, lo};
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one op in flight over a valid/ready handshake with flush.
module rv_muldiv_unit
  import rv_mdu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          EARLY_SPEC = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  rv_muldiv_unit_if.slave mdu
);

  localparam int unsigned   CW   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_lo_q, neg_hi_q;
  logic [XLEN-1:0]   operand_q;
  logic [2*XLEN-1:0] acc_q;

  logic              accept;
  logic              sign1, sign2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   early_res;
  logic [2*XLEN-1:0] cond_res;
  logic [2*XLEN-1:0] fix_res;
  logic              fix_sel_hi;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;

  assign accept = (state_q == S_IDLE) && mdu.in_valid && !mdu.flush;
  assign sign1  = src1_signed(mdu.op) && mdu.src1[XLEN-1];
  assign sign2  = src2_signed(mdu.op) && mdu.src2[XLEN-1];

  assign div_zero = is_div(mdu.op) && (mdu.src2 == '0);
  assign div_ovf  = ((mdu.op == MDU_DIV) || (mdu.op == MDU_REM)) &&
                    (mdu.src1 == SMIN) && (mdu.src2 == '1);
  assign special  = div_zero || div_ovf;

  // op[1] separates rem/remu from div/divu.
  always_comb begin
    early_res = '0;
    if (div_zero)     early_res = mdu.op[1] ? mdu.src1 : '1;
    else if (div_ovf) early_res = mdu.op[1] ? '0 : mdu.src1;
  end

  rv_mdu_signfix #(.XLEN(XLEN)) u_cond (
    .in_lo  (mdu.src1),
    .in_hi  (mdu.src2),
    .neg_lo (sign1),
    .neg_hi (sign2),
    .wide   (1'b0),
    .sel_hi (1'b0),
    .res    (cond_res)
  );

  assign fix_sel_hi = is_div(op_q) ? op_q[1] : (op_q != MDU_MUL);

  rv_mdu_signfix #(.XLEN(XLEN)) u_fix (
    .in_lo  (acc_q[XLEN-1:0]),
    .in_hi  (acc_q[2*XLEN-1:XLEN]),
    .neg_lo (neg_lo_q),
    .neg_hi (neg_hi_q),
    .wide   (!is_div(op_q)),
    .sel_hi (fix_sel_hi),
    .res    (fix_res)
  );

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, operand_q};
    div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (EARLY_SPEC && special) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (mdu.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (mdu.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      operand_q <= '0;
      acc_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q     <= mdu.op;
          cnt_q    <= CW'(XLEN - 1);
          neg_hi_q <= sign1;
          // A zero divisor must yield an all-ones quotient regardless of dividend sign.
          neg_lo_q <= is_div(mdu.op) ? ((sign1 ^ sign2) && !div_zero) : (sign1 ^ sign2);
          if (EARLY_SPEC && special) begin
            acc_q <= {{XLEN{1'b0}}, early_res};
          end else if (is_div(mdu.op)) begin
            operand_q <= cond_res[2*XLEN-1:XLEN];
            acc_q     <= {{XLEN{1'b0}}, cond_res[XLEN-1:0]};
          end else begin
            operand_q <= cond_res[XLEN-1:0];
            acc_q     <= {{XLEN{1'b0}}, cond_res[2*XLEN-1:XLEN]};
          end
        end
        S_CALC: begin
          acc_q <= is_div(op_q) ? div_next : mul_next;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX:   acc_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign mdu.in_ready  = (state_q == S_IDLE);
  assign mdu.out_valid = (state_q == S_DONE);
  assign mdu.busy      = (state_q != S_IDLE);
  assign mdu.result    = (state_q == S_DONE) ? acc_q[XLEN-1:0] : '0;

endmodule
